alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Command-side initiator for the team's 8-bit combinational ALU (ALU_8bit), sitting between the Tiny Tapeout byte I/O and the ALU.
- Accepts a byte stream (header, then operand bytes) over a valid/ready input port.
- Drives registered A/B/ALU_Sel into the ALU, captures ALU_Out/Zero/CarryOut, and returns the result over a valid/ready output port.
- Keeps an accumulator so operations can be chained on the previous result.

Parameters:
HEADER_TAG, 4'hA, required value of header bits [7:4]; any other value is a framing error.
TIMEOUT, 255, max idle cycles allowed between bytes of one command before abort; counter is 8 bits wide.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  8  command/operand byte
in_valid  input  1  in_data valid
in_ready  output  1  byte accepted when in_valid && in_ready
alu_a  output  8  ALU operand A (registered)
alu_b  output  8  ALU operand B (registered)
alu_sel  output  3  ALU opcode (registered)
alu_out  input  8  ALU result
alu_zero  input  1  ALU Zero flag
alu_carry  input  1  ALU CarryOut flag
res_data  output  8  captured result
res_flags  output  2  {carry, zero} captured with res_data
res_valid  output  1  result available
res_ready  input  1  result consumed when res_valid && res_ready
op_count  output  8  completed results, wraps 255->0
err  output  1  one-cycle pulse on framing error or timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE. alu_a, alu_b, alu_sel, res_data, res_flags, op_count, accumulator and timeout counter all 0. res_valid=0, err=0, in_ready=0 while in reset. Reset mid-command discards the partial command and any pending result.
- Header format: [7:4] tag, [3] chain, [2:0] opcode. Opcodes: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr, 111 slt.
- in_ready=1 in IDLE, GET_A and GET_B; 0 in EXEC and HOLD.
- IDLE:
  - Bad tag: byte dropped, err pulses next cycle, stay IDLE.
  - Valid header: latch opcode into alu_sel. chain=1 loads alu_a <= accumulator. chain=1 with shl/shr -> EXEC. chain=1 otherwise -> GET_B. chain=0 -> GET_A.
- GET_A: accepted byte -> alu_a. Opcode shl/shr -> alu_b <= 0 and go to EXEC; otherwise -> GET_B.
- GET_B: accepted byte -> alu_b; -> EXEC.
- EXEC: one cycle, ALU inputs stable. At the end of the cycle: res_data <= alu_out, res_flags <= {alu_carry, alu_zero}, accumulator <= alu_out, op_count++ (mod 256), res_valid <= 1; -> HOLD.
- Latency: res_valid rises 2 cycles after the final byte handshake cycle.
- HOLD:
  - res_valid, res_data and res_flags stay stable until the res_ready handshake.
  - On handshake: res_valid <= 0, -> IDLE.
  - The next header cannot be accepted in the same cycle.
- Timeout (GET_A/GET_B only):
  - Counter clears on every accepted byte and on entry to those states; it increments each cycle without a handshake.
  - Reaching TIMEOUT: err pulses, -> IDLE, partial command dropped; accumulator and op_count unchanged.
  - No timeout applies in IDLE or HOLD.
- err is never asserted for two consecutive cycles from a single event. In IDLE, a header presented in the same cycle as a timeout return is not accepted, because in_ready is based on the current state.
- alu_a/b/sel hold their last values between commands.

Test Plan:
- Add with carry: send 0xA0, 0xF0, 0x20, res_ready=1 -> res_data=0x10, res_flags=2'b10, res_valid 2 cycles after last byte, op_count=1.
- Sub to zero: send 0xA1, 0x05, 0x05 -> res_data=0x00, res_flags=2'b11. Chained shl 0xAD follows with no operand bytes -> alu_a=0x00, res_data=0x00, flags {0,1}.
- Chain: 0xA0, 0x08, 0x08 (res 0x10), then 0xAD -> res_data=0x20, carry=0. Then 0xAF, 0x30 (chained slt, 0x20<0x30) -> res_data=0x01, op_count=3.
- Framing and timeout:
  - Byte 0x30 in IDLE -> err pulse of 1 cycle, no res_valid, still accepts 0xA0 next.
  - 0xA0, 0x11, then idle 255 cycles -> err pulse, in_ready=1 in IDLE.
- Backpressure: hold res_ready=0 for 10 cycles after a result -> res_valid, res_data and res_flags stable; in_ready=0 and header bytes not consumed. Release -> one handshake, back to IDLE.
- Reset mid-command: after 0xA0, 0x44, pull rst_n low asynchronously -> all outputs 0 immediately, op_count=0. After release, a full add command completes normally.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Byte-stream command sequencer for the 8-bit ALU.
// Frames header/operand bytes, drives the ALU and returns results with flags.
module alu_cmd_sequencer #(
  parameter logic [3:0]  HEADER_TAG = 4'hA,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic [7:0] res_data,
  output logic [1:0] res_flags,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] op_count,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_HOLD
  } state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] res_q, res_d;
  logic [1:0] flags_q, flags_d;
  logic       rv_q, rv_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] to_q, to_d;
  logic       err_q, err_d;
  logic       hs;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == 3'b101) || (op == 3'b110);
  endfunction

  assign in_ready = rst_n && ((state_q == S_IDLE) ||
                              (state_q == S_GET_A) ||
                              (state_q == S_GET_B));
  assign hs = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    res_d   = res_q;
    flags_d = flags_q;
    rv_d    = rv_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    to_d    = 8'd0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hs) begin
          if (in_data[7:4] != HEADER_TAG) begin
            err_d = 1'b1;
          end else begin
            sel_d = in_data[2:0];
            if (in_data[3]) begin
              a_d     = acc_q;
              state_d = is_shift(in_data[2:0]) ? S_EXEC : S_GET_B;
            end else begin
              state_d = S_GET_A;
            end
          end
        end
      end
      S_GET_A: begin
        if (hs) begin
          a_d = in_data;
          if (is_shift(sel_q)) begin
            b_d     = 8'd0;
            state_d = S_EXEC;
          end else begin
            state_d = S_GET_B;
          end
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + 8'd1;
        end
      end
      S_GET_B: begin
        if (hs) begin
          b_d     = in_data;
          state_d = S_EXEC;
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + 8'd1;
        end
      end
      S_EXEC: begin
        res_d   = alu_out;
        flags_d = {alu_carry, alu_zero};
        acc_d   = alu_out;
        cnt_d   = cnt_q + 8'd1;
        rv_d    = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // Next header waits for the cycle after the result handshake.
        if (rv_q && res_ready) begin
          rv_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      sel_q   <= 3'd0;
      res_q   <= 8'd0;
      flags_q <= 2'd0;
      rv_q    <= 1'b0;
      cnt_q   <= 8'd0;
      acc_q   <= 8'd0;
      to_q    <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      rv_q    <= rv_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign res_data  = res_q;
  assign res_flags = flags_q;
  assign res_valid = rv_q;
  assign op_count  = cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU
// and a command-level reference model.
module tb_alu_cmd_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_zero;
  logic       alu_carry;
  logic [7:0] res_data;
  logic [1:0] res_flags;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] op_count;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_acc;
  logic [7:0] m_cnt;

  alu_cmd_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .alu_carry (alu_carry),
    .res_data  (res_data),
    .res_flags (res_flags),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .op_count  (op_count),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {carry, zero, out}
  function automatic logic [9:0] alu_f(input logic [2:0] s,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] o;
    logic       c;
    o = 8'd0;
    c = 1'b0;
    w = 9'd0;
    case (s)
      3'd0: begin w = {1'b0, a} + {1'b0, b}; o = w[7:0]; c = w[8]; end
      3'd1: begin w = {1'b0, a} + {1'b0, ~b} + 9'd1; o = w[7:0]; c = w[8]; end
      3'd2: o = a & b;
      3'd3: o = a | b;
      3'd4: o = a ^ b;
      3'd5: begin o = {a[6:0], 1'b0}; c = a[7]; end
      3'd6: begin o = {1'b0, a[7:1]}; c = a[0]; end
      default: o = (a < b) ? 8'd1 : 8'd0;
    endcase
    return {c, (o == 8'd0), o};
  endfunction

  assign {alu_carry, alu_zero, alu_out} = alu_f(alu_sel, alu_a, alu_b);

  function automatic logic shift_op(input logic [2:0] op);
    return (op == 3'd5) || (op == 3'd6);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic hs);
    in_data  = b;
    in_valid = 1'b1;
    hs       = in_ready;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic issue_cmd(input logic chain, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b,
                           input int gap, output logic hs_all);
    logic h;
    send_byte({4'hA, chain, op}, h);
    hs_all = h;
    if (!chain) begin
      repeat (gap) tick();
      send_byte(a, h);
      hs_all &= h;
    end
    if (!shift_op(op)) begin
      repeat (gap) tick();
      send_byte(b, h);
      hs_all &= h;
    end
  endtask

  task automatic get_result(output logic ok, output logic [7:0] d,
                            output logic [1:0] f, output int lat);
    ok  = 1'b0;
    lat = 0;
    d   = 8'd0;
    f   = 2'd0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (res_valid) begin
        d         = res_data;
        f         = res_flags;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        ok        = 1'b1;
      end else begin
        tick();
        lat++;
      end
    end
  endtask

  // Reference: result of a command given the model's accumulator.
  function automatic logic [9:0] model_cmd(input logic chain,
                                           input logic [2:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
    return alu_f(op, chain ? m_acc : a, shift_op(op) ? 8'd0 : b);
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    res_ready = 1'b0;
    m_acc     = 8'd0;
    m_cnt     = 8'd0;
    #3;
    n_tests++;
    if ({in_ready, res_valid, err, alu_a, alu_b, alu_sel,
         res_data, res_flags, op_count} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got a=%h b=%h sel=%h rd=%h rf=%b cnt=%h rdy=%b rv=%b err=%b, want all 0",
               alu_a, alu_b, alu_sel, res_data, res_flags, op_count,
               in_ready, res_valid, err);
    end
    #4 rst_n = 1'b1;
    tick();
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_idle_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_add_carry();
    logic hs, ok;
    logic [7:0] d;
    logic [1:0] f;
    int lat;
    issue_cmd(1'b0, 3'd0, 8'hF0, 8'h20, 0, hs);
    get_result(ok, d, f, lat);
    m_acc = 8'h10;
    m_cnt++;
    n_tests++;
    if (!(hs && ok) || d !== 8'h10 || f !== 2'b10) begin
      n_fail++;
      $display("FAIL add_carry: got hs=%b ok=%b d=%h f=%b want d=10 f=10",
               hs, ok, d, f);
    end
    n_tests++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL add_latency: got %0d extra cycles want 1", lat);
    end
    n_tests++;
    if (op_count !== m_cnt) begin
      n_fail++;
      $display("FAIL add_op_count: got %0d want %0d", op_count, m_cnt);
    end
  endtask

  task automatic test_sub_zero_shl();
    logic hs, ok;
    logic [7:0] d;
    logic [1:0] f;
    int lat;
    issue_cmd(1'b0, 3'd1, 8'h05, 8'h05, 0, hs);
    get_result(ok, d, f, lat);
    m_acc = 8'h00;
    m_cnt++;
    n_tests++;
    if (!(hs && ok) || d !== 8'h00 || f !== 2'b11) begin
      n_fail++;
      $display("FAIL sub_zero: got d=%h f=%b want d=00 f=11", d, f);
    end
    issue_cmd(1'b1, 3'd5, 8'h00, 8'h00, 0, hs);
    get_result(ok, d, f, lat);
    m_cnt++;
    n_tests++;
    if (!(hs && ok) || alu_a !== 8'h00 || d !== 8'h00 || f !== 2'b01) begin
      n_fail++;
      $display("FAIL chain_shl_zero: got a=%h d=%h f=%b want a=00 d=00 f=01",
               alu_a, d, f);
    end
  endtask

  task automatic test_chain();
    logic hs, ok;
    logic [7:0] d;
    logic [1:0] f;
    int lat;
    issue_cmd(1'b0, 3'd0, 8'h08, 8'h08, 0, hs);
    get_result(ok, d, f, lat);
    m_cnt++;
    issue_cmd(1'b1, 3'd5, 8'h00, 8'h00, 0, hs);
    get_result(ok, d, f, lat);
    m_cnt++;
    n_tests++;
    if (!(hs && ok) || d !== 8'h20 || f[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL chain_shl: got d=%h f=%b want d=20 carry=0", d, f);
    end
    issue_cmd(1'b1, 3'd7, 8'h00, 8'h30, 0, hs);
    get_result(ok, d, f, lat);
    m_cnt++;
    m_acc = 8'h01;
    n_tests++;
    if (!(hs && ok) || d !== 8'h01 || op_count !== m_cnt) begin
      n_fail++;
      $display("FAIL chain_slt: got d=%h cnt=%0d want d=01 cnt=%0d",
               d, op_count, m_cnt);
    end
  endtask

  task automatic test_framing();
    logic hs, ok, e1, e2, rv;
    logic [7:0] d, a, b;
    logic [1:0] f;
    logic [9:0] exp;
    int lat;
    send_byte(8'h30, hs);
    e1 = err;
    tick();
    e2 = err;
    rv = res_valid;
    n_tests++;
    if (hs !== 1'b1 || e1 !== 1'b1 || e2 !== 1'b0 || rv !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_tag: got hs=%b err=%b,%b rv=%b want 1 1,0 0",
               hs, e1, e2, rv);
    end
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    exp = model_cmd(1'b0, 3'd0, a, b);
    issue_cmd(1'b0, 3'd0, a, b, 0, hs);
    get_result(ok, d, f, lat);
    m_acc = exp[7:0];
    m_cnt++;
    n_tests++;
    if (!(hs && ok) || d !== exp[7:0] || f !== exp[9:8]) begin
      n_fail++;
      $display("FAIL after_bad_tag: got d=%h f=%b want d=%h f=%b",
               d, f, exp[7:0], exp[9:8]);
    end
  endtask

  task automatic test_timeout();
    logic hs, h2, ok, seen;
    logic [7:0] d, b;
    logic [1:0] f;
    logic [9:0] exp;
    int lat, errk;
    send_byte(8'hA0, hs);
    send_byte(8'h11, h2);
    errk = 0;
    for (int k = 1; k <= 300 && errk == 0; k++) begin
      tick();
      if (err) errk = k;
    end
    n_tests++;
    if (!(hs && h2) || errk !== 255) begin
      n_fail++;
      $display("FAIL timeout_cycle: got err at idle cycle %0d want 255", errk);
    end
    n_tests++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: got rdy=%b rv=%b want 1 0",
               in_ready, res_valid);
    end
    tick();
    n_tests++;
    if (err !== 1'b0 || op_count !== m_cnt) begin
      n_fail++;
      $display("FAIL timeout_after: got err=%b cnt=%0d want 0 %0d",
               err, op_count, m_cnt);
    end
    // 254 idle cycles is still in time.
    b = 8'($urandom_range(0, 255));
    exp = model_cmd(1'b1, 3'd0, 8'h00, b);
    send_byte(8'hA8, hs);
    seen = 1'b0;
    repeat (254) begin
      tick();
      seen |= err;
    end
    send_byte(b, h2);
    get_result(ok, d, f, lat);
    m_acc = exp[7:0];
    m_cnt++;
    n_tests++;
    if (!(hs && h2 && ok) || seen || d !== exp[7:0] || f !== exp[9:8]) begin
      n_fail++;
      $display("FAIL timeout_edge: got hs=%b,%b err=%b d=%h want d=%h",
               hs, h2, seen, d, exp[7:0]);
    end
  endtask

  task automatic test_backpressure();
    logic hs, stable, busy;
    logic [7:0] a, b, d0;
    logic [1:0] f0;
    logic [9:0] exp;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    exp = model_cmd(1'b0, 3'd4, a, b);
    issue_cmd(1'b0, 3'd4, a, b, 0, hs);
    tick();
    d0 = res_data;
    f0 = res_flags;
    n_tests++;
    if (!hs || res_valid !== 1'b1 || d0 !== exp[7:0] || f0 !== exp[9:8]) begin
      n_fail++;
      $display("FAIL bp_result: got rv=%b d=%h f=%b want 1 %h %b",
               res_valid, d0, f0, exp[7:0], exp[9:8]);
    end
    m_acc = exp[7:0];
    m_cnt++;
    stable = 1'b1;
    busy   = 1'b0;
    in_data  = 8'hA0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      busy |= in_ready;
      tick();
      if (res_valid !== 1'b1 || res_data !== d0 || res_flags !== f0)
        stable = 1'b0;
    end
    in_valid = 1'b0;
    n_tests++;
    if (!stable || busy) begin
      n_fail++;
      $display("FAIL bp_hold: got stable=%b ready_seen=%b want 1 0",
               stable, busy);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_tests++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== m_cnt) begin
      n_fail++;
      $display("FAIL bp_release: got rv=%b rdy=%b cnt=%0d want 0 1 %0d",
               res_valid, in_ready, op_count, m_cnt);
    end
  endtask

  task automatic test_random();
    logic hs, ok, chain, good;
    logic [2:0] op;
    logic [7:0] a, b, d, ea;
    logic [1:0] f;
    logic [9:0] exp;
    int lat;
    good = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        d = 8'($urandom_range(0, 255));
        if (d[7:4] == 4'hA) d[7:4] = 4'h3;
        send_byte(d, hs);
        if (!hs || err !== 1'b1) begin
          good = 1'b0;
          $display("FAIL rand_bad_tag %0d: got hs=%b err=%b want 1 1",
                   i, hs, err);
        end
        tick();
      end
      chain = 1'($urandom_range(0, 1));
      op    = 3'($urandom_range(0, 7));
      a     = 8'($urandom_range(0, 255));
      b     = 8'($urandom_range(0, 255));
      ea    = chain ? m_acc : a;
      exp   = model_cmd(chain, op, a, b);
      issue_cmd(chain, op, a, b, $urandom_range(0, 2), hs);
      repeat ($urandom_range(0, 3)) tick();
      get_result(ok, d, f, lat);
      m_acc = exp[7:0];
      m_cnt++;
      if (!(hs && ok) || d !== exp[7:0] || f !== exp[9:8] ||
          alu_sel !== op || alu_a !== ea || op_count !== m_cnt) begin
        good = 1'b0;
        $display("FAIL rand_cmd %0d: got d=%h f=%b sel=%h a=%h cnt=%0d want d=%h f=%b sel=%h a=%h cnt=%0d",
                 i, d, f, alu_sel, alu_a, op_count,
                 exp[7:0], exp[9:8], op, ea, m_cnt);
      end
    end
    n_tests++;
    if (!good) n_fail++;
  endtask

  task automatic test_reset_mid();
    logic hs, h2, ok;
    logic [7:0] d;
    logic [1:0] f;
    logic [9:0] exp;
    int lat;
    send_byte(8'hA0, hs);
    send_byte(8'h44, h2);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, res_valid, err, alu_a, alu_b, alu_sel,
         res_data, res_flags, op_count} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got a=%h b=%h sel=%h rd=%h cnt=%h rdy=%b want all 0",
               alu_a, alu_b, alu_sel, res_data, op_count, in_ready);
    end
    #3 rst_n = 1'b1;
    m_acc = 8'd0;
    m_cnt = 8'd0;
    tick();
    exp = model_cmd(1'b0, 3'd0, 8'h12, 8'h34);
    issue_cmd(1'b0, 3'd0, 8'h12, 8'h34, 0, hs);
    get_result(ok, d, f, lat);
    m_cnt++;
    n_tests++;
    if (!(hs && ok) || d !== exp[7:0] || f !== exp[9:8] ||
        op_count !== m_cnt || lat !== 1) begin
      n_fail++;
      $display("FAIL reset_recover: got d=%h f=%b cnt=%0d lat=%0d want %h %b 1 1",
               d, f, op_count, lat, exp[7:0], exp[9:8]);
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub_zero_shl();
    test_chain();
    test_framing();
    test_timeout();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
